// File: rtl/reg_bank_pkg.sv
// Shared constants and state type for the register bank and its init sequencer.
package reg_bank_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int REG_SP_IDX       = 29;
  localparam int SP_INIT_DEFAULT  = 227;
  localparam int NUM_REGS_DEFAULT = 32;

endpackage

// File: rtl/reg_bank_if.sv
// Register-bank access bus: one write-back port and two read ports.
// The master drives indices and write data; the slave returns read data.
interface reg_bank_if #(
  parameter int DATA_W = 32
);
  logic              RegWrite;
  logic [4:0]        WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [4:0]        ReadReg1;
  logic [4:0]        ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/reg_init_seq.sv
// Init sequencer: after reset, walks every register index once, emitting a
// clear value (or the stack-pointer seed for r29), then parks in READY.
module reg_init_seq
  import reg_bank_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SP_INIT = SP_INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  output logic              init_we,
  output logic [4:0]        init_idx,
  output logic [DATA_W-1:0] init_data
);

  localparam logic [0:0] S_INIT  = INIT;
  localparam logic [0:0] S_READY = READY;

  logic [0:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  // Next state: count through all 32 indices, leave INIT after index 31.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) state_d = S_READY;
    end
  end

  // State registers; reset restarts the sequence from index 0 at any time.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == S_INIT);
  // No write on the reset edge itself; the walk restarts cleanly next cycle.
  assign init_we   = busy & ~reset;
  assign init_idx  = cnt_q;
  assign init_data = (cnt_q == 5'(REG_SP_IDX)) ? DATA_W'(SP_INIT) : '0;

endmodule

// File: rtl/reg_bank.sv
// Register bank: NUM_REGS x DATA_W storage, one write port, two
// combinational read ports, r0 hardwired to zero, cleared by the init
// sequencer after reset. Define REG_BANK_BYPASS_EN to forward same-cycle
// write data to a read port that addresses the register being written.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int DATA_W   = 32,
  parameter int SP_INIT  = SP_INIT_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  reg_bank_if.slave    bus,
  output logic         busy
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

  logic              init_we;
  logic [4:0]        init_idx;
  logic [DATA_W-1:0] init_data;

  logic              we_d;
  logic [4:0]        widx_d;
  logic [DATA_W-1:0] wdata_d;
  logic              user_we;

  reg_init_seq #(
    .DATA_W  (DATA_W),
    .SP_INIT (SP_INIT)
  ) u_init (
    .clk       (clk),
    .reset     (reset),
    .busy      (busy),
    .init_we   (init_we),
    .init_idx  (init_idx),
    .init_data (init_data)
  );

  // User writes only count once init is done; index 0 is never stored.
  assign user_we = ~busy & bus.RegWrite & (bus.WriteReg != 5'd0);

  // Single write port: the sequencer owns it while busy, the bus afterwards.
  always_comb begin
    we_d    = user_we;
    widx_d  = bus.WriteReg;
    wdata_d = bus.WriteData;
    if (busy) begin
      we_d    = init_we;
      widx_d  = init_idx;
      wdata_d = init_data;
    end
  end

  // Storage; deliberately not reset, the init walk does the clearing.
  always_ff @(posedge clk) begin
    if (we_d && (32'(widx_d) < NUM_REGS)) regs_q[widx_d] <= wdata_d;
  end

  // Read port 1: zero for r0, out-of-range indices and while busy.
  always_comb begin
    bus.ReadData1 = '0;
    if (bus.ReadReg1 != 5'd0 && 32'(bus.ReadReg1) < NUM_REGS)
      bus.ReadData1 = regs_q[bus.ReadReg1];
`ifdef REG_BANK_BYPASS_EN
    if (user_we && bus.WriteReg == bus.ReadReg1) bus.ReadData1 = bus.WriteData;
`endif
    if (busy) bus.ReadData1 = '0;
  end

  // Read port 2: identical rules, fully independent of port 1.
  always_comb begin
    bus.ReadData2 = '0;
    if (bus.ReadReg2 != 5'd0 && 32'(bus.ReadReg2) < NUM_REGS)
      bus.ReadData2 = regs_q[bus.ReadReg2];
`ifdef REG_BANK_BYPASS_EN
    if (user_we && bus.WriteReg == bus.ReadReg2) bus.ReadData2 = bus.WriteData;
`endif
    if (busy) bus.ReadData2 = '0;
  end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus a randomized
// run, all compared against a simple array model of the register file.
module tb_reg_bank;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic busy;

  reg_bank_if #(.DATA_W(32)) bus ();

  reg_bank #(.NUM_REGS(32), .DATA_W(32), .SP_INIT(227)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: register contents and cycles of init still to run.
  logic [31:0] mregs [32];
  int          init_left = 32;

  // Advance the model for one clock edge using the inputs currently driven.
  task automatic model_edge();
    if (reset) begin
      init_left = 32;
    end else if (init_left > 0) begin
      init_left--;
      if (init_left == 0) begin
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mregs[29] = 32'd227;
      end
    end else if (bus.RegWrite && bus.WriteReg != 5'd0) begin
      mregs[bus.WriteReg] = bus.WriteData;
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    if (init_left > 0) return 32'd0;
    if (idx == 5'd0) return 32'd0;
    if (BYP && bus.RegWrite && bus.WriteReg == idx) return bus.WriteData;
    return mregs[idx];
  endfunction

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset         = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.WriteReg  = 5'd0;
    bus.WriteData = 32'd0;
    bus.ReadReg1  = 5'd0;
    bus.ReadReg2  = 5'd0;
  endtask

  // Reset, idle 40 cycles: busy exactly 32 cycles, then r29=227, rest 0.
  task automatic test_reset();
    int busy_cycles = 0;
    idle_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      bus.ReadReg1 = 5'(k);
      bus.ReadReg2 = 5'(31 - k);
      #1;
      vectors++;
      if (busy !== (k < 32)) begin
        errors++;
        $display("FAIL reset_busy cyc=%0d got=%b want=%b", k, busy, (k < 32));
      end
      if (k < 32 && (bus.ReadData1 !== 32'd0 || bus.ReadData2 !== 32'd0)) begin
        errors++;
        $display("FAIL init_read_zero cyc=%0d got=%h/%h want=0", k, bus.ReadData1, bus.ReadData2);
      end
      if (busy) busy_cycles++;
      cyc();
    end
    vectors++;
    if (busy_cycles != 32) begin
      errors++;
      $display("FAIL busy_len got=%0d want=32", busy_cycles);
    end
    for (int i = 0; i < 32; i++) begin
      bus.ReadReg1 = 5'(i);
      bus.ReadReg2 = 5'(31 - i);
      #1;
      vectors++;
      if (bus.ReadData1 !== ((i == 29) ? 32'd227 : 32'd0) ||
          bus.ReadData2 !== ((31 - i == 29) ? 32'd227 : 32'd0)) begin
        errors++;
        $display("FAIL post_init r%0d/r%0d got=%h/%h", i, 31 - i, bus.ReadData1, bus.ReadData2);
      end
    end
  endtask

  // Plain write then read-back, and a dropped write to r0.
  task automatic test_write_read();
    idle_inputs();
    bus.RegWrite = 1'b1; bus.WriteReg = 5'd5; bus.WriteData = 32'hDEADBEEF;
    cyc();
    bus.RegWrite = 1'b0; bus.ReadReg1 = 5'd5; bus.ReadReg2 = 5'd5;
    #1;
    vectors++;
    if (bus.ReadData1 !== 32'hDEADBEEF || bus.ReadData2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_r5 got=%h/%h want=deadbeef", bus.ReadData1, bus.ReadData2);
    end
    bus.RegWrite = 1'b1; bus.WriteReg = 5'd0; bus.WriteData = 32'h12345678;
    cyc();
    bus.RegWrite = 1'b0; bus.ReadReg1 = 5'd0; bus.ReadReg2 = 5'd5;
    #1;
    vectors++;
    if (bus.ReadData1 !== 32'd0 || bus.ReadData2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_r0 got=%h/%h want=0/deadbeef", bus.ReadData1, bus.ReadData2);
    end
  endtask

  // Same-cycle write/read of r7: forwarded with bypass, old value without.
  task automatic test_bypass();
    logic [31:0] want_now;
    idle_inputs();
    want_now = BYP ? 32'hA5A5A5A5 : 32'd0;
    bus.ReadReg1 = 5'd7; bus.ReadReg2 = 5'd7;
    bus.RegWrite = 1'b1; bus.WriteReg = 5'd7; bus.WriteData = 32'hA5A5A5A5;
    #1;
    vectors++;
    if (bus.ReadData1 !== want_now || bus.ReadData2 !== want_now) begin
      errors++;
      $display("FAIL same_cycle_r7 got=%h/%h want=%h", bus.ReadData1, bus.ReadData2, want_now);
    end
    cyc();
    bus.RegWrite = 1'b0;
    #1;
    vectors++;
    if (bus.ReadData1 !== 32'hA5A5A5A5 || bus.ReadData2 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL next_cycle_r7 got=%h/%h want=a5a5a5a5", bus.ReadData1, bus.ReadData2);
    end
  endtask

  // Write attempt during INIT is ignored; reads stay 0 throughout INIT.
  task automatic test_init_ignore();
    idle_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      bus.RegWrite  = (k == 10);
      bus.WriteReg  = 5'd3;
      bus.WriteData = 32'h11;
      bus.ReadReg1  = 5'd3;
      bus.ReadReg2  = 5'($urandom_range(31));
      #1;
      vectors++;
      if (bus.ReadData1 !== 32'd0 || bus.ReadData2 !== 32'd0) begin
        errors++;
        $display("FAIL init_ignore_rd cyc=%0d got=%h/%h want=0", k, bus.ReadData1, bus.ReadData2);
      end
      cyc();
    end
    idle_inputs();
    bus.ReadReg1 = 5'd3;
    #1;
    vectors++;
    if (busy !== 1'b0 || bus.ReadData1 !== 32'd0) begin
      errors++;
      $display("FAIL init_ignore_r3 busy=%b got=%h want busy=0 r3=0", busy, bus.ReadData1);
    end
  endtask

  // Fill r1..r31, reset, re-reset at INIT cycle 15: full 32-cycle re-clear.
  task automatic test_reset_midinit();
    int busy_cycles = 0;
    idle_inputs();
    for (int i = 1; i < 32; i++) begin
      bus.RegWrite = 1'b1; bus.WriteReg = 5'(i); bus.WriteData = 32'(i);
      cyc();
    end
    idle_inputs();
    bus.ReadReg1 = 5'd17; bus.ReadReg2 = 5'd29;
    #1;
    vectors++;
    if (bus.ReadData1 !== 32'd17 || bus.ReadData2 !== 32'd29) begin
      errors++;
      $display("FAIL fill got=%h/%h want=11/1d", bus.ReadData1, bus.ReadData2);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 15; k++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (busy) busy_cycles++;
      cyc();
    end
    vectors++;
    if (busy_cycles != 32) begin
      errors++;
      $display("FAIL rereset_busy_len got=%0d want=32", busy_cycles);
    end
    for (int i = 0; i < 32; i++) begin
      bus.ReadReg1 = 5'(i);
      bus.ReadReg2 = 5'(i);
      #1;
      vectors++;
      if (bus.ReadData1 !== ((i == 29) ? 32'd227 : 32'd0) || bus.ReadData2 !== bus.ReadData1) begin
        errors++;
        $display("FAIL rereset_r%0d got=%h/%h", i, bus.ReadData1, bus.ReadData2);
      end
    end
  endtask

  // Random traffic with occasional resets, checked every cycle.
  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset         = ($urandom_range(149) == 0);
      bus.RegWrite  = $urandom_range(1);
      bus.WriteReg  = 5'($urandom_range(31));
      bus.WriteData = $urandom;
      bus.ReadReg1  = ($urandom_range(3) == 0) ? bus.WriteReg : 5'($urandom_range(31));
      bus.ReadReg2  = ($urandom_range(3) == 0) ? bus.ReadReg1 : 5'($urandom_range(31));
      #1;
      vectors++;
      if (busy !== (init_left > 0) ||
          bus.ReadData1 !== exp_rd(bus.ReadReg1) ||
          bus.ReadData2 !== exp_rd(bus.ReadReg2)) begin
        errors++;
        $display("FAIL random cyc=%0d busy=%b rd=%h/%h want busy=%b rd=%h/%h",
                 k, busy, bus.ReadData1, bus.ReadData2, (init_left > 0),
                 exp_rd(bus.ReadReg1), exp_rd(bus.ReadReg2));
      end
      cyc();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    test_reset();
    test_write_read();
    test_bypass();
    test_init_ignore();
    test_reset_midinit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
